// File: rtl/ring_pkg.sv
// Shared ring codes, sequencer states and a constant helper for the alarm/chime block.
// Pure declarations; no timing, no flow control.
package ring_pkg;

  localparam logic [1:0] RING_OFF  = 2'b00;
  localparam logic [1:0] RING_SLOW = 2'b01;
  localparam logic [1:0] RING_FAST = 2'b10;

  typedef enum logic [1:0] {IDLE, CHIME, ALARM, SNOOZE} ring_state_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic [1:0] ring_code(input ring_state_t s);
    case (s)
      CHIME:   return RING_SLOW;
      ALARM:   return RING_FAST;
      default: return RING_OFF;
    endcase
  endfunction

endpackage

// File: rtl/ring_if.sv
// Time/alarm inputs, user pulses and ring/busy outputs of the ring sequencer.
// Plain wires; no handshake, inputs sampled every clk.
interface ring_if;
  logic       tick_1hz;
  logic [4:0] hour;
  logic [5:0] min;
  logic [5:0] sec;
  logic [4:0] al_hour;
  logic [5:0] al_min;
  logic       alarm_en;
  logic       stop;
  logic       snooze;
  logic [1:0] ring;
  logic       busy;

  modport master (
    output tick_1hz, hour, min, sec, al_hour, al_min, alarm_en, stop, snooze,
    input  ring, busy
  );

  modport slave (
    input  tick_1hz, hour, min, sec, al_hour, al_min, alarm_en, stop, snooze,
    output ring, busy
  );
endinterface

// File: rtl/ring_sec_timer.sv
// Loadable seconds down-counter shared by all ring states; expire is combinational.
// Load wins over tick, so a tick in the load cycle is not counted; no backpressure.
module ring_sec_timer #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         tick,
  output logic         expire
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (tick && (cnt != '0))
      cnt <= cnt - 1'b1;
  end

  // Firing on the tick that sees 1 makes a state last exactly the loaded tick count.
  assign expire = tick && (cnt == W'(1));

endmodule

// File: rtl/ring_ctrl.sv
// Hourly chime / alarm ring sequencer; optional snooze compiled in with RING_SNOOZE_EN.
// ring/busy registered, one cycle after the causing edge or pulse; no backpressure.
module ring_ctrl #(
  parameter int CHIME_SEC  = 4,
  parameter int ALARM_SEC  = 30,
  parameter int SNOOZE_SEC = 300,
  parameter int MAX_SNOOZE = 3
) (
  input  logic   clk,
  input  logic   rst_n,
  ring_if.slave  bus
);

  import ring_pkg::*;

`ifdef RING_SNOOZE_EN
  localparam int CW = $clog2(max2(max2(CHIME_SEC, ALARM_SEC), SNOOZE_SEC) + 1);
  localparam int SW = $clog2(MAX_SNOOZE + 1);
`else
  localparam int CW = $clog2(max2(CHIME_SEC, ALARM_SEC) + 1);
`endif

  ring_state_t   state, state_d;
  logic          chime_m, alarm_m, chime_m_q, alarm_m_q;
  logic          chime_start, alarm_start;
  logic          tmr_load, tmr_expire;
  logic [CW-1:0] tmr_val;

  assign chime_m = (bus.min == 6'd0) && (bus.sec == 6'd0);
  assign alarm_m = bus.alarm_en && (bus.hour == bus.al_hour) &&
                   (bus.min == bus.al_min) && (bus.sec == 6'd0);

  assign chime_start = chime_m && !chime_m_q;
  assign alarm_start = alarm_m && !alarm_m_q;

  ring_sec_timer #(.W(CW)) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val (tmr_val),
    .tick     (bus.tick_1hz),
    .expire   (tmr_expire)
  );

`ifdef RING_SNOOZE_EN
  logic [SW-1:0] snz_cnt, snz_cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) snz_cnt <= '0;
    else        snz_cnt <= snz_cnt_d;
  end
`else
  logic unused_snz;
  assign unused_snz = ^{bus.snooze, SNOOZE_SEC[0], MAX_SNOOZE[0]};
`endif

  // Match history resets high so a match already present at reset release is not an event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      chime_m_q <= 1'b1;
      alarm_m_q <= 1'b1;
      bus.ring  <= RING_OFF;
      bus.busy  <= 1'b0;
    end else begin
      state     <= state_d;
      chime_m_q <= chime_m;
      alarm_m_q <= alarm_m;
      bus.ring  <= ring_code(state_d);
      bus.busy  <= (state_d != IDLE);
    end
  end

  always_comb begin
    state_d  = state;
    tmr_load = 1'b0;
    tmr_val  = '0;
`ifdef RING_SNOOZE_EN
    snz_cnt_d = snz_cnt;
`endif
    // Alarm start outranks everything else, including a same-cycle stop.
    if (alarm_start) begin
      state_d  = ALARM;
      tmr_load = 1'b1;
      tmr_val  = CW'(ALARM_SEC);
`ifdef RING_SNOOZE_EN
      snz_cnt_d = '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (chime_start) begin
            state_d  = CHIME;
            tmr_load = 1'b1;
            tmr_val  = CW'(CHIME_SEC);
          end
        end
        CHIME: begin
          if (bus.stop || tmr_expire) begin
            state_d  = IDLE;
            tmr_load = 1'b1;
          end
        end
        ALARM: begin
          if (bus.stop || !bus.alarm_en) begin
            state_d  = IDLE;
            tmr_load = 1'b1;
`ifdef RING_SNOOZE_EN
          end else if (bus.snooze && (snz_cnt < SW'(MAX_SNOOZE))) begin
            state_d   = SNOOZE;
            tmr_load  = 1'b1;
            tmr_val   = CW'(SNOOZE_SEC);
            snz_cnt_d = snz_cnt + 1'b1;
`endif
          end else if (tmr_expire) begin
            state_d  = IDLE;
            tmr_load = 1'b1;
          end
        end
`ifdef RING_SNOOZE_EN
        SNOOZE: begin
          if (bus.stop || !bus.alarm_en) begin
            state_d  = IDLE;
            tmr_load = 1'b1;
          end else if (tmr_expire) begin
            state_d  = ALARM;
            tmr_load = 1'b1;
            tmr_val  = CW'(ALARM_SEC);
          end
        end
`endif
        default: begin
          state_d  = IDLE;
          tmr_load = 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ring_ctrl.sv
// Directed bench for ring_ctrl: chime, alarm, stop, pre-empt, snooze and reset behaviour.
module tb_ring_ctrl;
  import ring_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  ring_if bus ();

  ring_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    repeat (n) begin
      bus.tick_1hz = 1'b1;
      cyc(1);
      bus.tick_1hz = 1'b0;
      cyc(1);
    end
  endtask

  task automatic set_time(input int h, input int m, input int s);
    bus.hour = 5'(h);
    bus.min  = 6'(m);
    bus.sec  = 6'(s);
  endtask

  task automatic pulse_stop();
    bus.stop = 1'b1;
    cyc(1);
    bus.stop = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [1:0] r_exp, input logic b_exp);
    total++;
    assert (bus.ring === r_exp) else begin
      bad++;
      $error("FAIL %s ring got=%b exp=%b", tag, bus.ring, r_exp);
    end
    total++;
    assert (bus.busy === b_exp) else begin
      bad++;
      $error("FAIL %s busy got=%b exp=%b", tag, bus.busy, b_exp);
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.tick_1hz = 1'b0;
    bus.stop     = 1'b0;
    bus.snooze   = 1'b0;
    bus.alarm_en = 1'b0;
    bus.al_hour  = 5'd7;
    bus.al_min   = 6'd30;
    set_time(10, 15, 20);
    cyc(3);
    chk("reset", RING_OFF, 1'b0);
    rst_n = 1'b1;
    cyc(2);
    chk("idle", RING_OFF, 1'b0);

    // Hourly chime: 4 ticks of slow pattern, no retrigger while sec holds at 0.
    set_time(12, 0, 0);
    cyc(1);
    chk("chime_start", RING_SLOW, 1'b1);
    tick_n(3);
    chk("chime_3ticks", RING_SLOW, 1'b1);
    tick_n(1);
    chk("chime_end", RING_OFF, 1'b0);
    cyc(5);
    chk("chime_no_retrig", RING_OFF, 1'b0);
    set_time(12, 0, 1);

    // Alarm for 30 ticks.
    bus.alarm_en = 1'b1;
    set_time(7, 30, 0);
    cyc(1);
    chk("alarm_start", RING_FAST, 1'b1);
    tick_n(29);
    chk("alarm_29ticks", RING_FAST, 1'b1);
    tick_n(1);
    chk("alarm_end", RING_OFF, 1'b0);
    set_time(7, 30, 1);
    cyc(1);

    // Disarmed alarm does nothing.
    bus.alarm_en = 1'b0;
    set_time(7, 30, 0);
    cyc(2);
    chk("alarm_disarmed", RING_OFF, 1'b0);
    set_time(7, 30, 1);
    bus.alarm_en = 1'b1;
    cyc(1);

    // Stop five ticks into the alarm.
    set_time(7, 30, 0);
    cyc(1);
    chk("stop_pre", RING_FAST, 1'b1);
    tick_n(5);
    pulse_stop();
    chk("stop_alarm", RING_OFF, 1'b0);
    set_time(7, 30, 1);
    cyc(1);

    // Stop coincident with alarm start loses; then disarming ends the alarm.
    set_time(7, 30, 0);
    bus.stop = 1'b1;
    cyc(1);
    bus.stop = 1'b0;
    chk("stop_vs_start", RING_FAST, 1'b1);
    bus.alarm_en = 1'b0;
    cyc(1);
    chk("alarm_en_drop", RING_OFF, 1'b0);
    bus.alarm_en = 1'b1;
    set_time(7, 30, 1);
    cyc(1);

    // Alarm at 08:00 pre-empts the hourly chime.
    bus.al_hour = 5'd8;
    bus.al_min  = 6'd0;
    set_time(7, 59, 59);
    cyc(1);
    set_time(8, 0, 0);
    cyc(1);
    chk("preempt_start", RING_FAST, 1'b1);
    tick_n(29);
    chk("preempt_29ticks", RING_FAST, 1'b1);
    tick_n(1);
    chk("preempt_end", RING_OFF, 1'b0);
    set_time(8, 0, 1);
    bus.al_hour = 5'd7;
    bus.al_min  = 6'd30;
    cyc(1);

    // Snooze.
    set_time(7, 30, 0);
    cyc(1);
    chk("snz_alarm", RING_FAST, 1'b1);
    set_time(7, 30, 1);
`ifdef RING_SNOOZE_EN
    for (int i = 0; i < 3; i++) begin
      bus.snooze = 1'b1;
      cyc(1);
      bus.snooze = 1'b0;
      chk($sformatf("snz%0d_enter", i), RING_OFF, 1'b1);
      tick_n(299);
      chk($sformatf("snz%0d_299", i), RING_OFF, 1'b1);
      tick_n(1);
      chk($sformatf("snz%0d_realarm", i), RING_FAST, 1'b1);
    end
    bus.snooze = 1'b1;
    cyc(1);
    bus.snooze = 1'b0;
    chk("snz_4th_ignored", RING_FAST, 1'b1);
`else
    bus.snooze = 1'b1;
    cyc(1);
    bus.snooze = 1'b0;
    chk("snz_disabled", RING_FAST, 1'b1);
`endif
    pulse_stop();
    chk("snz_stop", RING_OFF, 1'b0);
    cyc(1);

    // Asynchronous reset mid-alarm, released while the match still holds.
    set_time(7, 30, 0);
    cyc(1);
    chk("rst_pre", RING_FAST, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("rst_async", RING_OFF, 1'b0);
    cyc(2);
    rst_n = 1'b1;
    cyc(3);
    chk("rst_no_restart", RING_OFF, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
